deco_frame_feeder: RTL and testbench

Upstream stage of the Deco turbo decoder. Buffers complete 84-bit coded frames in a small FIFO and serializes each frame into four 21-bit words. It drives Deco's start/data protocol, waits for Deco's done pulse, and only then issues the next frame. It also counts completed frames and flags protocol violations and timeouts.

---
 rtl/deco_frame_feeder.sv | 152 +++++++++++++++
 tb/tb_deco_frame_feeder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/deco_frame_feeder.sv
// Frame buffer and serializer for Deco: a pushed frame pops one cycle later, then goes out as WORDS words plus one hold word.
// Backpressure: frame_ready_o drops while the FIFO is full; the next frame waits for Deco's done_i.
module deco_frame_feeder #(
    parameter  int WORD_W     = 21,
    parameter  int WORDS      = 4,
    parameter  int FIFO_DEPTH = 2,
    parameter  int CNT_W      = 16,
    parameter  int TIMEOUT    = 1024,
    localparam int FRAME_W    = WORD_W * WORDS,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_p_i,
    input  logic               reset_p_i,
    input  logic               frame_valid_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               frame_ready_o,
    output logic               start_o,
    output logic [WORD_W-1:0]  data_o,
    input  logic               done_i,
    output logic               busy_o,
    output logic [LVL_W-1:0]   fifo_level_o,
    output logic [CNT_W-1:0]   frame_cnt_o,
    output logic               proto_err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t                       state_q, state_d;
    logic [FRAME_W-1:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]             level_q, level_d;
    logic [WORDS-1:0][WORD_W-1:0] frame_q;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic                         full, push, pop;

    // Ready comes from the registered level only, so a same-cycle pop never frees a slot early.
    assign full          = (level_q == LVL_W'(FIFO_DEPTH));
    assign frame_ready_o = !full;
    assign push          = frame_valid_i && !full;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pop     = 1'b0;
        start_o = 1'b0;
        data_o  = '0;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                start_o = 1'b1;
                data_o  = frame_q[idx_q];
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    state_d = S_HOLD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_HOLD: begin
                start_o = 1'b1;
                data_o  = frame_q[WORDS-1];
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_i) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A done pulse outside WAIT cannot belong to the frame in flight.
        if (done_i && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_p_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= frame_i;
        end
    end

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            frame_q  <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                frame_q  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign fifo_level_o = level_q;
    assign frame_cnt_o  = cnt_q;
    assign proto_err_o  = err_q;

endmodule

// File: tb/tb_deco_frame_feeder.sv
// Directed bench for deco_frame_feeder: serialization order, FIFO full/ordering, done misuse, timeout, mid-frame reset.
module tb_deco_frame_feeder;

    logic        clk_p_i = 1'b0;
    logic        reset_p_i = 1'b0;
    logic        frame_valid_i = 1'b0;
    logic [83:0] frame_i = '0;
    logic        frame_ready_o;
    logic        start_o;
    logic [20:0] data_o;
    logic        done_i = 1'b0;
    logic        busy_o;
    logic [1:0]  fifo_level_o;
    logic [15:0] frame_cnt_o;
    logic        proto_err_o;

    int          errs = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;
    logic        saw_start;

    localparam logic [83:0] FA = {21'h4, 21'h3, 21'h2, 21'h1};
    localparam logic [83:0] F0 = {21'h1F0003, 21'h0A0002, 21'h150001, 21'h000F00};
    localparam logic [83:0] F1 = {21'h111111, 21'h011112, 21'h101113, 21'h001114};
    localparam logic [83:0] F2 = {21'h022221, 21'h122222, 21'h022223, 21'h122224};
    localparam logic [83:0] F3 = {21'h033331, 21'h033332, 21'h133333, 21'h033334};
    localparam logic [83:0] F4 = {21'h1ABCDE, 21'h012345, 21'h0FEDCB, 21'h1FFFFF};
    localparam logic [83:0] F5 = {21'h000001, 21'h100000, 21'h0AAAAA, 21'h155555};
    localparam logic [83:0] F6 = {21'h066666, 21'h077777, 21'h088888, 21'h099999};

    deco_frame_feeder dut (
        .clk_p_i       (clk_p_i),
        .reset_p_i     (reset_p_i),
        .frame_valid_i (frame_valid_i),
        .frame_i       (frame_i),
        .frame_ready_o (frame_ready_o),
        .start_o       (start_o),
        .data_o        (data_o),
        .done_i        (done_i),
        .busy_o        (busy_o),
        .fifo_level_o  (fifo_level_o),
        .frame_cnt_o   (frame_cnt_o),
        .proto_err_o   (proto_err_o)
    );

    always #5 clk_p_i = ~clk_p_i;

    task automatic chk(input string tag, input logic [83:0] got, input logic [83:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p_i);
        #1;
    endtask

    task automatic do_reset();
        reset_p_i     = 1'b1;
        frame_valid_i = 1'b0;
        done_i        = 1'b0;
        tick();
        reset_p_i = 1'b0;
        exp_cnt   = '0;
    endtask

    task automatic push(input logic [83:0] f);
        frame_valid_i = 1'b1;
        frame_i       = f;
        tick();
        frame_valid_i = 1'b0;
    endtask

    // Expects words 0..3 then word 3 again; optionally pulses done_i during beat done_at.
    task automatic run_frame(input logic [83:0] f, input int done_at);
        logic [20:0] w;
        int          idx;
        for (int i = 0; i < 20 && start_o !== 1'b1; i++) tick();
        chk("start_seen", start_o, 1);
        for (int k = 0; k < 5; k++) begin
            idx = (k < 4) ? k : 3;
            w   = f[idx*21 +: 21];
            chk("start_hi", start_o, 1);
            chk("data_word", data_o, w);
            done_i = (k == done_at);
            tick();
        end
        done_i = 1'b0;
        chk("wait_start_lo", start_o, 0);
        chk("wait_data_zero", data_o, 0);
        chk("wait_busy", busy_o, 1);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick();
        done_i  = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("frame_cnt", frame_cnt_o, exp_cnt);
        chk("idle_after_done", busy_o, 0);
        chk("start_lo_idle", start_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_ready", frame_ready_o, 1);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_cnt", frame_cnt_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", proto_err_o, 0);

        // Single frame, data 1,2,3,4,4; done three cycles after HOLD
        push(FA);
        chk("a_level", fifo_level_o, 1);
        chk("a_start_pre", start_o, 0);
        run_frame(FA, -1);
        tick();
        tick();
        chk("a_cnt_before_done", frame_cnt_o, 0);
        pulse_done();

        // Deco stalled: two frames buffer, the third is dropped
        push(F0);
        run_frame(F0, -1);
        push(F1);
        chk("b_level1", fifo_level_o, 1);
        chk("b_ready1", frame_ready_o, 1);
        push(F2);
        chk("b_level2", fifo_level_o, 2);
        chk("b_ready_full", frame_ready_o, 0);
        push(F3);
        chk("b_level_ignored", fifo_level_o, 2);
        pulse_done();
        run_frame(F1, -1);
        chk("b_level_after_pop", fifo_level_o, 1);
        chk("b_ready_again", frame_ready_o, 1);
        pulse_done();
        run_frame(F2, -1);
        chk("b_level_empty", fifo_level_o, 0);
        pulse_done();
        saw_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_start |= start_o;
        end
        chk("b_no_dropped_frame", saw_start, 0);
        chk("b_err_clear", proto_err_o, 0);

        // Push and pop on the same edge at level 1
        push(F4);
        chk("c_level1", fifo_level_o, 1);
        push(F5);
        chk("c_level_same_edge", fifo_level_o, 1);
        run_frame(F4, -1);
        pulse_done();
        run_frame(F5, -1);
        pulse_done();
        chk("c_err_clear", proto_err_o, 0);

        // done_i during SEND flags an error but the frame completes
        push(F6);
        run_frame(F6, 1);
        chk("d_err_set", proto_err_o, 1);
        chk("d_cnt_unchanged", frame_cnt_o, exp_cnt);
        pulse_done();

        // Timeout: WAIT lasts 1024 cycles without done_i
        do_reset();
        chk("e_err_reset", proto_err_o, 0);
        chk("e_cnt_reset", frame_cnt_o, 0);
        push(F1);
        push(F2);
        run_frame(F1, -1);
        repeat (1023) tick();
        chk("e_still_wait", busy_o, 1);
        chk("e_err_not_yet", proto_err_o, 0);
        tick();
        chk("e_idle_after_tmo", busy_o, 0);
        chk("e_err_tmo", proto_err_o, 1);
        chk("e_cnt_tmo", frame_cnt_o, 0);
        run_frame(F2, -1);
        pulse_done();

        // Reset while word 2 of a frame is on the bus
        push(F3);
        push(F4);
        tick();
        tick();
        chk("f_word2", data_o, F3[62:42]);
        chk("f_level_pre", fifo_level_o, 1);
        reset_p_i = 1'b1;
        tick();
        reset_p_i = 1'b0;
        exp_cnt   = '0;
        chk("f_start_lo", start_o, 0);
        chk("f_data_zero", data_o, 0);
        chk("f_level_zero", fifo_level_o, 0);
        chk("f_busy", busy_o, 0);
        chk("f_ready", frame_ready_o, 1);
        chk("f_err", proto_err_o, 0);
        chk("f_cnt", frame_cnt_o, 0);
        saw_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_start |= start_o;
        end
        chk("f_no_words_after_reset", saw_start, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
